// File: rtl/axi4_duth_noc_pkg.sv
// NoC link flow-control types and paired sender/receiver presets.
// Receiver presets must match the sender presets they connect to.
package axi4_duth_noc_pkg;

  typedef enum logic {
    FLOW_CONTROL_CREDITS,
    FLOW_CONTROL_ELASTIC
  } flow_control_type;

  typedef struct packed {
    flow_control_type FC_TYPE;
    int unsigned      BUFF_DEPTH;
  } link_fc_params_snd_type;

  typedef struct packed {
    flow_control_type FC_TYPE;
    int unsigned      BUFF_DEPTH;
    bit               REG_CR_UPD;
  } link_fc_params_rcv_type;

  localparam link_fc_params_snd_type RTR_CREDITS_3_FC_SND = '{
    FC_TYPE:    FLOW_CONTROL_CREDITS,
    BUFF_DEPTH: 3
  };

  localparam link_fc_params_snd_type RTR_ELASTIC_2_FC_SND = '{
    FC_TYPE:    FLOW_CONTROL_ELASTIC,
    BUFF_DEPTH: 2
  };

  localparam link_fc_params_rcv_type RTR_CREDITS_3_FC_RCV = '{
    FC_TYPE:    FLOW_CONTROL_CREDITS,
    BUFF_DEPTH: 3,
    REG_CR_UPD: 1'b0
  };

  localparam link_fc_params_rcv_type RTR_ELASTIC_2_FC_RCV = '{
    FC_TYPE:    FLOW_CONTROL_ELASTIC,
    BUFF_DEPTH: 2,
    REG_CR_UPD: 1'b0
  };

  function automatic int unsigned fc_cnt_w(
    input int unsigned depth
  );
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

  function automatic int unsigned fc_ptr_w(
    input int unsigned depth
  );
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/fc_rcv_fifo.sv
// Circular flit buffer for the link receiver; accepts a push
// while full when a pop happens in the same cycle.
module fc_rcv_fifo
  import axi4_duth_noc_pkg::*;
#(
  parameter int unsigned W     = 16,
  parameter int unsigned DEPTH = 3,
  parameter int unsigned CW    = fc_cnt_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int unsigned PW = fc_ptr_w(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign count   = cnt;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_pop)  rd_ptr <= nxt(rd_ptr);
      if (do_push) wr_ptr <= nxt(wr_ptr);
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Payload storage needs no reset; count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/flow_control_receiver.sv
// Receiving end of a NoC link: buffers flits and returns
// credit pulses (credit mode) or a ready level (elastic mode).
module flow_control_receiver
  import axi4_duth_noc_pkg::*;
#(
  parameter int unsigned      LINK_WIDTH = 16,
  parameter flow_control_type FC_TYPE    = FLOW_CONTROL_CREDITS,
  parameter int unsigned      BUFF_DEPTH = 3,
  parameter bit               REG_CR_UPD = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LINK_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic                  back_notify,
  output logic [LINK_WIDTH-1:0] data_out,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic                  overflow_err
);

  localparam bit IS_CR = (FC_TYPE == FLOW_CONTROL_CREDITS);

  if (IS_CR && BUFF_DEPTH < 1) begin : g_bad_cr
    $error("credit mode needs BUFF_DEPTH >= 1");
  end
  if (!IS_CR && BUFF_DEPTH == 1) begin : g_bad_el
    $error("elastic mode cannot use BUFF_DEPTH == 1");
  end

  if (!IS_CR && BUFF_DEPTH == 0) begin : g_wire
    assign data_out     = data_in;
    assign valid_out    = valid_in;
    assign back_notify  = ready_in;
    assign overflow_err = 1'b0;
  end else begin : g_buf
    localparam int unsigned CW = fc_cnt_w(BUFF_DEPTH);

    logic          push;
    logic          pop;
    logic          full;
    logic          empty_unused;
    logic [CW-1:0] count;

    fc_rcv_fifo #(
      .W     (LINK_WIDTH),
      .DEPTH (BUFF_DEPTH),
      .CW    (CW)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (data_in),
      .pop       (pop),
      .head      (data_out),
      .count     (count),
      .full      (full),
      .empty     (empty_unused)
    );

    assign valid_out = (count != '0);
    assign pop       = valid_out & ready_in;

    if (IS_CR) begin : g_cr
      logic ovf_q;

      // Sender owns the credits, so every valid flit is a push.
      assign push         = valid_in;
      assign overflow_err = ovf_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst)                      ovf_q <= 1'b0;
        else if (valid_in & full & ~pop) ovf_q <= 1'b1;
      end

      if (REG_CR_UPD) begin : g_reg
        logic cr_q;
        always_ff @(posedge clk or posedge rst) begin
          if (rst) cr_q <= 1'b0;
          else     cr_q <= pop;
        end
        assign back_notify = cr_q;
      end else begin : g_comb
        assign back_notify = pop;
      end
    end else begin : g_el
      // Ready comes from registered count only.
      assign back_notify  = ~full;
      assign push         = valid_in & ~full;
      assign overflow_err = 1'b0;
    end
  end

endmodule
